// File: rtl/instruction_fetch.sv
// Instruction fetch stage: issues read requests to instruction memory at the
// fetch address, holds each returned word for decode, and supplies the next
// program counter value. Supports flush/redirect at any point, including
// while a memory read is still outstanding.
module instruction_fetch #(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 32,
  parameter int ADDR_STEP = 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [ADDR_W-1:0] pc_in,
  output logic [ADDR_W-1:0] next_address,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              instr_valid,
  output logic [DATA_W-1:0] instr,
  output logic [ADDR_W-1:0] instr_pc,
  input  logic              decode_ready,
  input  logic              flush,
  input  logic [ADDR_W-1:0] flush_target
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    HOLD  = 2'd2,
    DRAIN = 2'd3
  } state_t;

  localparam logic [ADDR_W-1:0] STEP = ADDR_W'(ADDR_STEP);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] fetch_addr_q, fetch_addr_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic              mem_req_q, mem_req_d;
  logic              instr_valid_q, instr_valid_d;
  logic [DATA_W-1:0] instr_q, instr_d;
  logic [ADDR_W-1:0] instr_pc_q, instr_pc_d;
  logic              accept_s;
  logic              capture_s;
  logic              new_req_s;

  // State and datapath registers; synchronous reset wins over everything
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= IDLE;
      fetch_addr_q  <= {ADDR_W{1'b0}};
      mem_addr_q    <= {ADDR_W{1'b0}};
      mem_req_q     <= 1'b0;
      instr_valid_q <= 1'b0;
      instr_q       <= {DATA_W{1'b0}};
      instr_pc_q    <= {ADDR_W{1'b0}};
    end else begin
      state_q       <= state_d;
      fetch_addr_q  <= fetch_addr_d;
      mem_addr_q    <= mem_addr_d;
      mem_req_q     <= mem_req_d;
      instr_valid_q <= instr_valid_d;
      instr_q       <= instr_d;
      instr_pc_q    <= instr_pc_d;
    end
  end

  // Next-state logic; a flush while a read is outstanding must wait for its ack
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        state_d = REQ;
      end
      REQ: begin
        if (flush) begin
          state_d = mem_ack ? REQ : DRAIN;
        end else if (mem_ack) begin
          state_d = HOLD;
        end else begin
          state_d = REQ;
        end
      end
      HOLD: begin
        if (flush || decode_ready) begin
          state_d = REQ;
        end else begin
          state_d = HOLD;
        end
      end
      DRAIN: begin
        if (mem_ack) begin
          state_d = REQ;
        end else begin
          state_d = DRAIN;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Datapath and output decode: fetch address, next PC, captured instruction
  always_comb begin
    accept_s     = (state_q == HOLD) && decode_ready && !flush;
    capture_s    = (state_q == REQ) && mem_ack && !flush;
    fetch_addr_d = fetch_addr_q;
    next_address = fetch_addr_q;
    if (reset) begin
      next_address = pc_in;
    end else if (flush) begin
      fetch_addr_d = flush_target;
      next_address = flush_target;
    end else if (state_q == IDLE) begin
      fetch_addr_d = pc_in;
      next_address = pc_in;
    end else if (accept_s) begin
      fetch_addr_d = fetch_addr_q + STEP;
      next_address = fetch_addr_q + STEP;
    end else begin
      fetch_addr_d = fetch_addr_q;
      next_address = fetch_addr_q;
    end

    instr_d    = capture_s ? mem_rdata : instr_q;
    instr_pc_d = capture_s ? fetch_addr_q : instr_pc_q;

    if (flush) begin
      instr_valid_d = 1'b0;
    end else if (capture_s) begin
      instr_valid_d = 1'b1;
    end else if (accept_s) begin
      instr_valid_d = 1'b0;
    end else begin
      instr_valid_d = instr_valid_q;
    end

    // A new read starts only when no earlier one is still outstanding,
    // so mem_addr stays frozen across a drain.
    new_req_s  = (state_d == REQ) &&
                 ((state_q == IDLE) || (state_q == HOLD) || mem_ack);
    mem_addr_d = new_req_s ? fetch_addr_d : mem_addr_q;
    mem_req_d  = (state_d == REQ) || (state_d == DRAIN);
  end

  assign mem_req     = mem_req_q;
  assign mem_addr    = mem_addr_q;
  assign instr_valid = instr_valid_q;
  assign instr       = instr_q;
  assign instr_pc    = instr_pc_q;

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch: a program_counter model closes the
// next_address loop, memory acks are driven step by step, and every word
// delivered to decode is checked against a scoreboard queue.
module tb_instruction_fetch;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] pc_in;
  logic [31:0] next_address;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        decode_ready;
  logic        flush;
  logic [31:0] flush_target;

  logic [31:0] pc_q;
  logic [31:0] pc_rst_val;

  typedef struct {
    logic [31:0] data;
    logic [31:0] pc;
  } exp_t;
  exp_t sb[$];

  int vectors     = 0;
  int miscompares = 0;

  instruction_fetch #(.DATA_W(32), .ADDR_W(32), .ADDR_STEP(1)) dut (
    .clock        (clock),
    .reset        (reset),
    .pc_in        (pc_in),
    .next_address (next_address),
    .mem_req      (mem_req),
    .mem_addr     (mem_addr),
    .mem_ack      (mem_ack),
    .mem_rdata    (mem_rdata),
    .instr_valid  (instr_valid),
    .instr        (instr),
    .instr_pc     (instr_pc),
    .decode_ready (decode_ready),
    .flush        (flush),
    .flush_target (flush_target)
  );

  always #5 clock = ~clock;

  // program_counter model loaded from next_address
  always @(posedge clock) begin
    pc_q <= reset ? pc_rst_val : next_address;
  end
  assign pc_in = pc_q;

  function automatic logic [31:0] dat(input logic [31:0] a);
    return a ^ 32'h5A5A_0000;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Apply inputs for one cycle and retire scoreboard entries seen by decode
  task automatic drive(input logic ack, input logic [31:0] rdata, input logic rdy,
                       input logic fl, input logic [31:0] tgt);
    exp_t e;
    mem_ack = ack; mem_rdata = rdata; decode_ready = rdy;
    flush = fl; flush_target = tgt;
    #1;
    if (!reset && instr_valid) begin
      chk("sb_nonempty", {31'd0, sb.size() > 0}, 32'd1);
      if (sb.size() > 0) begin
        if (fl) begin
          void'(sb.pop_front());
        end else if (rdy) begin
          e = sb.pop_front();
          chk("sb_instr", instr, e.data);
          chk("sb_pc", instr_pc, e.pc);
        end
      end
    end
  endtask

  task automatic edge_();
    @(posedge clock);
    #1;
  endtask

  // DUT is in REQ at exp_pc; hold off the ack for lat cycles, then return data
  task automatic fetch_one(input int lat, input logic [31:0] exp_pc);
    chk("req_on", {31'd0, mem_req}, 32'd1);
    chk("req_addr", mem_addr, exp_pc);
    for (int i = 0; i < lat; i++) begin
      drive(1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
      edge_();
      chk("wait_req", {31'd0, mem_req}, 32'd1);
      chk("wait_addr", mem_addr, exp_pc);
      chk("wait_valid", {31'd0, instr_valid}, 32'd0);
    end
    sb.push_back('{dat(exp_pc), exp_pc});
    drive(1'b1, dat(exp_pc), 1'b0, 1'b0, 32'd0);
    edge_();
    chk("ack_valid", {31'd0, instr_valid}, 32'd1);
    chk("ack_instr", instr, dat(exp_pc));
    chk("ack_pc", instr_pc, exp_pc);
    chk("hold_noreq", {31'd0, mem_req}, 32'd0);
  endtask

  // Decode takes the held instruction; fetch moves to exp_next
  task automatic accept_one(input logic [31:0] exp_next);
    drive(1'b0, 32'd0, 1'b1, 1'b0, 32'd0);
    chk("acc_next", next_address, exp_next);
    edge_();
    chk("acc_valid", {31'd0, instr_valid}, 32'd0);
    chk("acc_req", {31'd0, mem_req}, 32'd1);
    chk("acc_addr", mem_addr, exp_next);
    chk("acc_pc", pc_in, exp_next);
  endtask

  task automatic do_reset(input logic [31:0] rv);
    pc_rst_val = rv;
    reset = 1'b1;
    drive(1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
    edge_();
    edge_();
  endtask

  initial begin
    reset = 1'b1; pc_rst_val = 32'd30;
    mem_ack = 1'b0; mem_rdata = 32'd0; decode_ready = 1'b0;
    flush = 1'b0; flush_target = 32'd0;

    // 1: reset values, start at PC 30, zero-wait fetches 30,31,32
    do_reset(32'd30);
    chk("rst_req", {31'd0, mem_req}, 32'd0);
    chk("rst_valid", {31'd0, instr_valid}, 32'd0);
    chk("rst_instr", instr, 32'd0);
    chk("rst_ipc", instr_pc, 32'd0);
    reset = 1'b0;
    drive(1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
    chk("idle_next", next_address, 32'd30);
    edge_();
    chk("idle_pc", pc_in, 32'd30);
    fetch_one(0, 32'd30); accept_one(32'd31);
    fetch_one(0, 32'd31); accept_one(32'd32);
    fetch_one(0, 32'd32); accept_one(32'd33);

    // 2: four-cycle memory latency from PC 0
    do_reset(32'd0);
    reset = 1'b0;
    drive(1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
    edge_();
    fetch_one(4, 32'd0); accept_one(32'd1);

    // 3: decode stalls five cycles in HOLD
    fetch_one(0, 32'd1);
    for (int i = 0; i < 5; i++) begin
      drive(1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
      chk("stall_next", next_address, 32'd1);
      edge_();
      chk("stall_valid", {31'd0, instr_valid}, 32'd1);
      chk("stall_instr", instr, dat(32'd1));
      chk("stall_ipc", instr_pc, 32'd1);
      chk("stall_req", {31'd0, mem_req}, 32'd0);
    end
    accept_one(32'd2);

    // 4: flush to 100 during REQ at 2, ack two cycles later with DEAD
    drive(1'b0, 32'd0, 1'b0, 1'b1, 32'd100);
    chk("fl_next", next_address, 32'd100);
    edge_();
    chk("drain_req", {31'd0, mem_req}, 32'd1);
    chk("drain_addr", mem_addr, 32'd2);
    chk("drain_pc", pc_in, 32'd100);
    drive(1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
    edge_();
    drive(1'b1, 32'h0000_DEAD, 1'b0, 1'b0, 32'd0);
    edge_();
    chk("dead_valid", {31'd0, instr_valid}, 32'd0);
    chk("redir_addr", mem_addr, 32'd100);
    fetch_one(0, 32'd100); accept_one(32'd101);

    // flush coinciding with an ack in REQ drops the data
    drive(1'b1, 32'h0000_0BAD, 1'b0, 1'b1, 32'd7);
    edge_();
    chk("flack_valid", {31'd0, instr_valid}, 32'd0);
    chk("flack_req", {31'd0, mem_req}, 32'd1);
    chk("flack_addr", mem_addr, 32'd7);

    // 5: flush with decode_ready in HOLD at pc 7
    fetch_one(0, 32'd7);
    drive(1'b0, 32'd0, 1'b1, 1'b1, 32'd200);
    chk("hfl_next", next_address, 32'd200);
    edge_();
    chk("hfl_valid", {31'd0, instr_valid}, 32'd0);
    chk("hfl_addr", mem_addr, 32'd200);
    chk("hfl_pc", pc_in, 32'd200);
    fetch_one(0, 32'd200); accept_one(32'd201);

    // 6: reset mid-REQ with a late ack during reset, then address wrap
    drive(1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
    edge_();
    pc_rst_val = 32'd15;
    reset = 1'b1;
    drive(1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
    edge_();
    drive(1'b1, 32'h0000_BEEF, 1'b0, 1'b0, 32'd0);
    edge_();
    chk("mrst_req", {31'd0, mem_req}, 32'd0);
    chk("mrst_valid", {31'd0, instr_valid}, 32'd0);
    reset = 1'b0;
    drive(1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
    chk("mrst_next", next_address, 32'd15);
    edge_();
    chk("mrst_addr", mem_addr, 32'd15);
    drive(1'b1, 32'h0000_0BAD, 1'b0, 1'b1, 32'hFFFF_FFFF);
    edge_();
    fetch_one(0, 32'hFFFF_FFFF); accept_one(32'd0);
    fetch_one(0, 32'd0); accept_one(32'd1);
    chk("sb_drained", sb.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
